// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: sequencing controller for a Gray-code counter.
// Owns the Gray state register and steps it from 0 to a latched terminal
// code, either once (done pulse) or continuously (wrap pulse plus lap count).
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LAPW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] term_gray,
  input  logic             step_en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [LAPW-1:0]  lap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAPW-1:0]  ZERO_L = {LAPW{1'b0}};
  localparam logic [LAPW-1:0]  ONE_L  = {{(LAPW-1){1'b0}}, 1'b1};
  localparam logic [LAPW-1:0]  MAX_L  = {LAPW{1'b1}};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: adjacent-bit XOR.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] term_r, term_s;
  logic             mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             wrap_r, wrap_s;
  logic [LAPW-1:0]  lap_r, lap_s;
  logic [WIDTH-1:0] gray_inc_s;

  // Successor Gray code; binary all-ones rolls over to zero naturally.
  assign gray_inc_s = bin2gray(gray2bin(q_r) + ONE_W);

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    term_s  = term_r;
    mode_s  = mode_r;
    lap_s   = lap_r;
    done_s  = 1'b0;
    wrap_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_s = ST_RUN;
          q_s     = ZERO_W;
          term_s  = term_gray;
          mode_s  = mode;
          lap_s   = ZERO_L;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort beats any step or terminal action.
          state_s = ST_IDLE;
          q_s     = ZERO_W;
        end else if (step_en) begin
          if (q_r == term_r) begin
            if (mode_r) begin
              q_s    = ZERO_W;
              wrap_s = 1'b1;
              lap_s  = (lap_r == MAX_L) ? MAX_L : (lap_r + ONE_L);
            end else begin
              state_s = ST_FINISH;
              done_s  = 1'b1;
            end
          end else begin
            q_s = gray_inc_s;
          end
        end else begin
          q_s = q_r;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        q_s     = ZERO_W;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      q_r     <= ZERO_W;
      term_r  <= ZERO_W;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
      lap_r   <= ZERO_L;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      term_r  <= term_s;
      mode_r  <= mode_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      wrap_r  <= wrap_s;
      lap_r   <= lap_s;
    end
  end

  assign q       = q_r;
  assign bin     = gray2bin(q_r);
  assign busy    = busy_r;
  assign done    = done_r;
  assign wrap    = wrap_r;
  assign lap_cnt = lap_r;

endmodule
